ncpu32k_dcache_linefill: RTL and testbench

NCPU32K_DCACHE_LINEFILL -- requirements
Module: ncpu32k_dcache_linefill

---
 rtl/ncpu32k_dcache_linefill.sv | 181 ++++++++++++++++++
 tb/tb_ncpu32k_dcache_linefill.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ncpu32k_dcache_linefill.sv
// rtl/ncpu32k_dcache_linefill.sv - D-cache line writeback and refill sequencer
// Optional feature macro: NCPU_DCACHE_CRIT_WORD_FIRST_EN (critical-word-first refill order).
module ncpu32k_dcache_linefill #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int LW = 2,
  parameter int PW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dirty,
  input  logic [AW-LW-1:0] req_idx,
  input  logic [PW-1:0]    req_victim_pa,
  input  logic [PW-1:0]    req_fill_pa,
  output logic             done,
  output logic             ram_en,
  output logic [AW-1:0]    ram_addr,
  output logic [DW/8-1:0]  ram_we,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout,
  output logic             mem_cmd_valid,
  input  logic             mem_cmd_ready,
  output logic             mem_cmd_we,
  output logic [PW-1:0]    mem_cmd_addr,
  output logic             mem_wvalid,
  input  logic             mem_wready,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_rvalid,
  output logic             mem_rready,
  input  logic [DW-1:0]    mem_rdata
);
  localparam int BB = $clog2(DW / 8);
  localparam int AL = BB + LW;
  localparam logic [PW-1:0] LINE_MASK = {{(PW-AL){1'b1}}, {AL{1'b0}}};
`ifdef NCPU_DCACHE_CRIT_WORD_FIRST_EN
  localparam logic [PW-1:0] FILL_MASK = {{(PW-BB){1'b1}}, {BB{1'b0}}};
`else
  localparam logic [PW-1:0] FILL_MASK = LINE_MASK;
`endif

  typedef enum logic [2:0] {IDLE, WB_CMD, WB_RD, WB_DAT, RF_CMD, RF_DAT, DONE} state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    beat_q, beat_d;
  logic [DW-1:0]    hold_q, hold_d;
  logic             fresh_q, fresh_d;
  logic [AW-LW-1:0] idx_q, idx_d;
  logic [PW-1:0]    victim_q, victim_d;
  logic [PW-1:0]    fill_q, fill_d;
  logic [LW-1:0]    fill_off, fill_word;
  logic [DW-1:0]    wb_data;
  logic             last_beat;

  assign last_beat = &beat_q;
`ifdef NCPU_DCACHE_CRIT_WORD_FIRST_EN
  assign fill_off = fill_q[BB +: LW];
`else
  assign fill_off = '0;
`endif
  assign fill_word = beat_q + fill_off;
  // RAM data is only valid in the first WB_DAT cycle; later stall cycles replay the hold copy.
  assign wb_data = fresh_q ? ram_dout : hold_q;

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    hold_d        = hold_q;
    fresh_d       = 1'b0;
    idx_d         = idx_q;
    victim_d      = victim_q;
    fill_d        = fill_q;
    req_ready     = 1'b0;
    done          = 1'b0;
    ram_en        = 1'b0;
    ram_addr      = '0;
    ram_we        = '0;
    ram_din       = '0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    mem_rready    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          idx_d    = req_idx;
          victim_d = req_victim_pa;
          fill_d   = req_fill_pa;
          state_d  = req_dirty ? WB_CMD : RF_CMD;
        end
      end
      WB_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = 1'b1;
        mem_cmd_addr  = victim_q & LINE_MASK;
        if (mem_cmd_ready) begin
          beat_d  = '0;
          state_d = WB_RD;
        end
      end
      WB_RD: begin
        ram_en   = 1'b1;
        ram_addr = {idx_q, beat_q};
        fresh_d  = 1'b1;
        state_d  = WB_DAT;
      end
      WB_DAT: begin
        mem_wvalid = 1'b1;
        mem_wdata  = wb_data;
        hold_d     = wb_data;
        if (mem_wready) begin
          beat_d  = beat_q + 1'b1;
          state_d = last_beat ? RF_CMD : WB_RD;
        end
      end
      RF_CMD: begin
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = fill_q & FILL_MASK;
        if (mem_cmd_ready) begin
          beat_d  = '0;
          state_d = RF_DAT;
        end
      end
      RF_DAT: begin
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          ram_en   = 1'b1;
          ram_we   = '1;
          ram_din  = mem_rdata;
          ram_addr = {idx_q, fill_word};
          beat_d   = beat_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset silences every output in the cycle it is sampled, so an aborted refill cannot write.
    if (rst) begin
      req_ready     = 1'b0;
      done          = 1'b0;
      ram_en        = 1'b0;
      ram_addr      = '0;
      ram_we        = '0;
      ram_din       = '0;
      mem_cmd_valid = 1'b0;
      mem_cmd_we    = 1'b0;
      mem_cmd_addr  = '0;
      mem_wvalid    = 1'b0;
      mem_wdata     = '0;
      mem_rready    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      hold_q   <= '0;
      fresh_q  <= 1'b0;
      idx_q    <= '0;
      victim_q <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      hold_q   <= hold_d;
      fresh_q  <= fresh_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
      fill_q   <= fill_d;
    end
  end
endmodule

// File: tb/tb_ncpu32k_dcache_linefill.sv
// tb/tb_ncpu32k_dcache_linefill.sv - directed and random line operations against a line-level model
module tb_ncpu32k_dcache_linefill;
`ifdef NCPU_DCACHE_CRIT_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_dirty = 1'b0;
  logic [5:0]  req_idx = '0;
  logic [31:0] req_victim_pa = '0, req_fill_pa = '0;
  logic        done, ram_en;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_din, ram_dout;
  logic        mem_cmd_valid, mem_cmd_ready = 1'b0, mem_cmd_we;
  logic [31:0] mem_cmd_addr;
  logic        mem_wvalid, mem_wready = 1'b1;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0, mem_rready;
  logic [31:0] mem_rdata = '0;

  logic [31:0] ram_mem [0:255];
  logic [31:0] exp_mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ncpu32k_dcache_linefill dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dirty(req_dirty), .req_idx(req_idx),
    .req_victim_pa(req_victim_pa), .req_fill_pa(req_fill_pa), .done(done),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata)
  );

  // Read-first data RAM with a preload port for the bench.
  always @(posedge clk) begin
    if (pl_en) begin
      ram_mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      ram_dout <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    exp_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic check_ram(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (ram_mem[i] !== exp_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic run_op(input bit dirty, input logic [5:0] idx, input logic [31:0] vpa,
                        input logic [31:0] fpa, input int stall_beat, input int stall_len,
                        input int abort_after);
    logic [31:0] exp_addr_q[$];
    bit          exp_we_q[$];
    int          wb_given = 0, rf_given = 0, stalled = 0, cyc = 0, last_r = -10, last_w = -10;
    bit          wb_out = 1'b0, rf_out = 1'b0, finished = 1'b0, aborted = 1'b0;
    logic [1:0]  off, w;
    logic [7:0]  base;
    logic [3:0]  exp_we;
    base = {idx, 2'b00};
    off  = CWF ? fpa[3:2] : 2'd0;
    if (dirty) begin exp_we_q.push_back(1'b1); exp_addr_q.push_back(vpa & ~32'hF); end
    exp_we_q.push_back(1'b0);
    exp_addr_q.push_back(CWF ? (fpa & ~32'h3) : (fpa & ~32'hF));

    @(negedge clk);
    req_valid = 1'b1; req_dirty = dirty; req_idx = idx; req_victim_pa = vpa; req_fill_pa = fpa;
    #1 chk("req_ready_idle", req_ready, 1);
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      req_valid     = 1'b0;
      mem_cmd_ready = 1'($urandom_range(0, 1));
      mem_wready    = 1'b1;
      if (mem_wvalid && wb_given == stall_beat && stalled < stall_len) begin
        mem_wready = 1'b0;
        stalled++;
      end
      mem_rvalid = rf_out && ($urandom_range(0, 3) != 0);
      mem_rdata  = $urandom;
      if (abort_after >= 0 && rf_out && rf_given == abort_after) begin
        rst = 1'b1; mem_rvalid = 1'b1;
        #1;
        chk("abort_rst_ram_we", ram_we, 0);
        chk("abort_rst_ram_en", ram_en, 0);
        chk("abort_rst_req_ready", req_ready, 0);
        chk("abort_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("abort_idle_req_ready", req_ready, 1);
        chk("abort_ram_we", ram_we, 0);
        chk("abort_done", done, 0);
        finished = 1'b1; aborted = 1'b1;
      end else begin
        #1;
        exp_we = (rf_out && mem_rvalid) ? 4'hF : 4'h0;
        chk("ram_we", ram_we, exp_we);
        if (mem_cmd_valid) chk("cmd_during_burst", wb_out | rf_out, 0);
        if (mem_cmd_valid && mem_cmd_ready) begin
          chk("cmd_expected", exp_we_q.size() > 0, 1);
          if (exp_we_q.size() > 0) begin
            chk("cmd_we", mem_cmd_we, exp_we_q.pop_front());
            chk("cmd_addr", mem_cmd_addr, exp_addr_q.pop_front());
            if (mem_cmd_we) wb_out = 1'b1; else rf_out = 1'b1;
          end
        end
        if (mem_wvalid && !mem_wready) begin
          chk("stall_wdata", mem_wdata, exp_mem[base + 8'(wb_given)]);
          chk("stall_ram_en", ram_en, 0);
        end
        if (wb_out && mem_wvalid && mem_wready) begin
          chk("wdata", mem_wdata, exp_mem[base + 8'(wb_given)]);
          if (wb_given > 0)
            chk("wb_spacing", cyc - last_w, 2 + ((wb_given == stall_beat) ? stall_len : 0));
          last_w = cyc;
          wb_given++;
          if (wb_given == 4) wb_out = 1'b0;
        end
        if (rf_out && mem_rvalid) begin
          w = off + 2'(rf_given);
          chk("rf_addr", ram_addr, {idx, w});
          chk("rf_din", ram_din, mem_rdata);
          exp_mem[{idx, w}] = mem_rdata;
          last_r = cyc;
          rf_given++;
          if (rf_given == 4) rf_out = 1'b0;
        end
        if (done) begin
          chk("done_timing", cyc, last_r + 1);
          chk("done_beats", rf_given, 4);
          @(negedge clk);
          mem_rvalid = 1'b0;
          #1;
          chk("done_one_cycle", done, 0);
          chk("back_to_idle", req_ready, 1);
          finished = 1'b1;
        end
      end
    end
    mem_rvalid = 1'b0;
    chk("op_finished", finished, 1);
    if (!aborted) chk("cmds_left", exp_we_q.size(), 0);
    check_ram("ram_contents");
  endtask

  initial begin
    @(negedge clk); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_cmd_valid", mem_cmd_valid, 0);
    chk("rst_wvalid", mem_wvalid, 0);
    chk("rst_rready", mem_rready, 0);
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_req_ready", req_ready, 1);

    // Clean miss into line 5.
    run_op(1'b0, 6'd5, 32'h0, 32'h1000, -1, 0, -1);
    // Dirty miss, known victim data, no stall.
    preload(8'd12, 32'hAAAA_0001); preload(8'd13, 32'hBBBB_0002);
    preload(8'd14, 32'hCCCC_0003); preload(8'd15, 32'hDDDD_0004);
    run_op(1'b1, 6'd3, 32'h2004, 32'h3000, -1, 0, -1);
    // Dirty miss with wready held low for 5 cycles on beat 2.
    preload(8'd12, 32'hAAAA_0001); preload(8'd13, 32'hBBBB_0002);
    preload(8'd14, 32'hCCCC_0003); preload(8'd15, 32'hDDDD_0004);
    run_op(1'b1, 6'd3, 32'h2004, 32'h3000, 2, 5, -1);
    // Unaligned fill address: word order depends on critical-word-first.
    run_op(1'b0, 6'd1, 32'h0, 32'h100C, -1, 0, -1);
    // Reset after two refill beats, then a normal operation.
    run_op(1'b1, 6'd9, 32'h4010, 32'h5008, -1, 0, 2);
    run_op(1'b0, 6'd9, 32'h0, 32'h5004, -1, 0, -1);
    for (int n = 0; n < 12; n++)
      run_op(1'($urandom_range(0, 1)), 6'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
